// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op and state encodings plus small decode helpers used by the datapath and FSM.
package mips_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared {acc_hi, acc_lo} accumulator.
// Multiply: shift-add with the multiplier in acc_lo. Divide: restoring shift-subtract, quotient shifts into acc_lo.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  muldiv_op_t         op,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (op_is_div(op)) begin
            // The partial remainder stays below the divisor, so diff's top bit is a pure borrow flag.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write path.
// Works on magnitudes for WIDTH cycles, then applies sign fix-ups and special cases in SIGN.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t      state_reg,  state_next;
    logic [CNT_W-1:0]   count_reg,  count_next;
    logic [2*WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0]   opnd_reg,   opnd_next;
    muldiv_op_t         op_reg,     op_next;
    logic               sign_a_reg, sign_a_next;
    logic               sign_b_reg, sign_b_next;
    logic [WIDTH-1:0]   hi_reg,     hi_next;
    logic [WIDTH-1:0]   lo_reg,     lo_next;

    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
    logic [2*WIDTH-1:0] prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_reg),
        .opnd     (opnd_reg),
        .op       (op_reg),
        .acc_next (step_acc)
    );

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        op_next     = op_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        a_abs       = '0;
        b_abs       = '0;
        quo         = '0;
        rem         = '0;
        prod        = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_a_next = op_is_signed(op) & a[WIDTH-1];
                    sign_b_next = op_is_signed(op) & b[WIDTH-1];
                    a_abs       = sign_a_next ? -a : a;
                    b_abs       = sign_b_next ? -b : b;
                    op_next     = op;
                    count_next  = '0;
                    state_next  = CALC;
                    // acc_lo holds the multiplier (mul) or the dividend (div); opnd is the other operand.
                    if (op_is_div(op)) begin
                        acc_next  = {{WIDTH{1'b0}}, a_abs};
                        opnd_next = b_abs;
                    end else begin
                        acc_next  = {{WIDTH{1'b0}}, b_abs};
                        opnd_next = a_abs;
                    end
                end
            end
            CALC: begin
                acc_next   = step_acc;
                count_next = count_reg + 1'b1;
                if (count_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                if (op_is_div(op_reg)) begin
                    // 0x8000_0000 / -1 needs no special path: |q| = 2^31 negates back onto itself, remainder 0.
                    quo = acc_reg[WIDTH-1:0];
                    rem = acc_reg[2*WIDTH-1:WIDTH];
                    if (sign_a_reg ^ sign_b_reg) quo = -quo;
                    if (sign_a_reg)              rem = -rem;
                    // With a zero divisor the remainder already equals |a|, so only lo needs forcing.
                    if (opnd_reg == '0)          quo = '1;
                    hi_next = rem;
                    lo_next = quo;
                end else begin
                    prod    = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
                    hi_next = prod[2*WIDTH-1:WIDTH];
                    lo_next = prod[WIDTH-1:0];
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            op_reg     <= MULT;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            op_reg     <= op_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a cycle-level arithmetic model.
// The model tracks cycles since accept and the expected {hi,lo}; a negedge process compares every cycle.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int LAT = 34;

    logic        clk;
    logic        reset;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    bit run_chk = 0;

    int          m_t   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [63:0] m_res = '0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            MULT:  p = 64'(sx * sy);
            MULTU: p = {32'b0, x} * {32'b0, y};
            DIV: begin
                if (y == 0)                                   p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == '1)       p = {32'h0, 32'h8000_0000};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {32'(r), 32'(q)};
                end
            end
            DIVU: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else        p = {x % y, x / y};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Model: m_t counts cycles since accept (0 = idle); result becomes visible on the done cycle.
    always @(posedge clk) begin
        if (!reset) begin
            m_t  = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_res = model(op, a, b);
                m_t   = 1;
            end
        end else if (m_t == LAT) begin
            m_t = 0;
        end else begin
            m_t = m_t + 1;
            if (m_t == LAT) {m_hi, m_lo} = m_res;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("busy", 64'(busy), 64'(m_t != 0));
            chk("done", 64'(done), 64'(m_t == LAT));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Issue one op from an idle negedge; returns at the first idle negedge afterwards.
    task automatic do_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input bit lit, input logic [31:0] eh, input logic [31:0] el, input bit glitch);
        int busy_n;
        int done_at;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        busy_n  = 0;
        done_at = 0;
        for (int c = 1; c <= 60; c++) begin
            if (busy) busy_n++;
            if (done && done_at == 0) begin
                done_at = c;
                if (lit) begin
                    chk("lit_hi", 64'(hi), 64'(eh));
                    chk("lit_lo", 64'(lo), 64'(el));
                end
            end
            if (!busy) break;
            if (glitch && c == 10) begin
                start = 1'b1;
                op = muldiv_op_t'(2'($urandom_range(0, 3)));
                a = $urandom;
                b = $urandom;
            end
            if (glitch && c == 11) start = 1'b0;
            @(negedge clk);
        end
        chk("done_latency", 64'(done_at), 64'(LAT));
        chk("busy_cycles", 64'(busy_n), 64'(LAT));
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", o, x, y, hi, lo);
    endtask

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 80);
        chk(nm, 64'(done), 64'(1));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        start = 1'b1;
        op    = MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'd2;
        @(negedge clk);
        run_chk = 1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);

        do_op(MULTU, 32'hFFFF_FFFF, 32'd2,        1, 32'h1,         32'hFFFF_FFFE, 0);
        do_op(MULT,  32'hFFFF_FFFD, 32'd7,        1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op(MULT,  32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0,        0);
        do_op(DIV,   32'hFFFF_FFF9, 32'd2,        1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op(DIVU,  32'd100,       32'd7,        1, 32'd2,         32'd14,        0);
        do_op(DIVU,  32'd5,         32'd0,        1, 32'd5,         32'hFFFF_FFFF, 0);
        do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0,        32'h8000_0000, 0);
        do_op(DIV,   32'hFFFF_FFF9, 32'd0,        1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        // start pulsed mid-CALC with other operands must not disturb the first result
        do_op(DIVU,  32'd100,       32'd7,        1, 32'd2,         32'd14,        1);

        // start held through DONE: next op accepted on the single IDLE cycle
        op = MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
        wait_done("hold_first_done");
        chk("hold_first_lo", 64'(lo), 64'(15));
        op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        chk("hold_idle_gap", 64'(busy), 64'(0));
        @(negedge clk);
        chk("hold_reaccept", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done("hold_second_done");
        chk("hold_second_hi", 64'(hi), 64'(2));
        chk("hold_second_lo", 64'(lo), 64'(14));
        $display("hold-start second result hi=%08h lo=%08h", hi, lo);
        @(negedge clk);

        // reset mid-CALC aborts with no done pulse and clears hi/lo
        op = MULT; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        repeat (40) @(negedge clk);
        chk("abort_still_idle", 64'(busy), 64'(0));
        $display("mid-CALC reset: busy=%0b hi=%08h lo=%08h", busy, hi, lo);

        for (int i = 0; i < 30; i++) begin
            do_op(muldiv_op_t'(2'($urandom_range(0, 3))), pick(), pick(), 0, '0, '0, (i % 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        run_chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
